// File: rtl/ladybird_config_pkg.sv
// ladybird_config: shared configuration for ladybird memories and arbiters.
`default_nettype none

package ladybird_config;

   localparam int XLEN = 32;

   // Index width that stays at least one bit wide for a single master.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ladybird_arb_core.sv
// ladybird_arb_core: N-way request/grant arbiter, one-hot and binary grant outputs.
// Macro LADYBIRD_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (index 0 highest).
`default_nettype none

module ladybird_arb_core
   import ladybird_config::*;
#(
   parameter int N_INPUT = 2,
   localparam int IDX_W  = idx_w(N_INPUT)
) (
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
   input  logic               clk,
   input  logic               anrst,
`endif
   input  logic [N_INPUT-1:0] req,
   output logic [N_INPUT-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Scan from the farthest offset down so the requester nearest the pointer wins last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int k = N_INPUT - 1; k >= 0; k--) begin : b_scan
         int j;
         j = int'(ptr_q) + k;
         if (j >= N_INPUT) j = j - N_INPUT;
         if (req[j]) begin
            gnt     = '0;
            gnt[j]  = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (|req) begin
         if (gnt_idx == IDX_W'(N_INPUT - 1)) ptr_d = '0;
         else                                ptr_d = gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int k = N_INPUT - 1; k >= 0; k--) begin
         if (req[k]) begin
            gnt     = '0;
            gnt[k]  = 1'b1;
            gnt_idx = IDX_W'(k);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/ladybird_arbitrated_ram.sv
// ladybird_arbitrated_ram: single-port byte-strobed RAM behind an N-master arbiter.
// Macro LADYBIRD_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
`default_nettype none

module ladybird_arbitrated_ram
   import ladybird_config::*;
#(
   parameter int N_INPUT = 2,
   parameter int DATA_W  = XLEN,
   parameter int ADDR_W  = 3
) (
   input  logic                            clk,
   input  logic                            anrst,
   input  logic [N_INPUT-1:0]              req,
   output logic [N_INPUT-1:0]              gnt,
   input  logic [N_INPUT-1:0][31:0]        addr,
   input  logic [N_INPUT-1:0][DATA_W/8-1:0] wstrb,
   input  logic [N_INPUT-1:0][DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]               rdata,
   output logic [N_INPUT-1:0]              data_gnt
);

   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int IDX_W  = idx_w(N_INPUT);

   logic [IDX_W-1:0]   gnt_idx;
   logic [31:0]        sel_addr;
   logic [STRB_W-1:0]  sel_wstrb;
   logic [DATA_W-1:0]  sel_wdata;
   logic [ADDR_W-1:0]  word_idx;
   logic               wr_en, rd_en;
   logic               addr_unused;

   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [N_INPUT-1:0] data_gnt_q, data_gnt_d;

   ladybird_arb_core #(.N_INPUT(N_INPUT)) u_arb (
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
      .clk     (clk),
      .anrst   (anrst),
`endif
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_addr  = addr[gnt_idx];
   assign sel_wstrb = wstrb[gnt_idx];
   assign sel_wdata = wdata[gnt_idx];
   // Byte offset and high address bits are dropped so addresses wrap on the depth.
   assign word_idx    = sel_addr[ADDR_W+1:2];
   assign addr_unused = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

   assign wr_en = (|gnt) && (|sel_wstrb);
   assign rd_en = (|gnt) && !(|sel_wstrb);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (sel_wstrb[k]) mem_q[word_idx][8*k +: 8] <= sel_wdata[8*k +: 8];
         end
      end
   end

   always_comb begin
      rdata_d    = rdata_q;
      data_gnt_d = '0;
      if (rd_en) begin
         rdata_d    = mem_q[word_idx];
         data_gnt_d = gnt;
      end
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         rdata_q    <= '0;
         data_gnt_q <= '0;
      end else begin
         rdata_q    <= rdata_d;
         data_gnt_q <= data_gnt_d;
      end
   end

   assign rdata    = rdata_q;
   assign data_gnt = data_gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ladybird_arbitrated_ram.sv
// tb_ladybird_arbitrated_ram: directed table plus randomized traffic against a memory model.
`default_nettype none

module tb_ladybird_arbitrated_ram;

   localparam int N = 2;

   logic             clk = 1'b0;
   logic             anrst = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N-1:0]     gnt;
   logic [N-1:0][31:0] addr = '0;
   logic [N-1:0][3:0]  wstrb = '0;
   logic [N-1:0][31:0] wdata = '0;
   logic [31:0]      rdata;
   logic [N-1:0]     data_gnt;

   ladybird_arbitrated_ram #(.N_INPUT(N), .DATA_W(32), .ADDR_W(3)) dut (
      .clk      (clk),
      .anrst    (anrst),
      .req      (req),
      .gnt      (gnt),
      .addr     (addr),
      .wstrb    (wstrb),
      .wdata    (wdata),
      .rdata    (rdata),
      .data_gnt (data_gnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_mem [8];
   logic [31:0] m_rdata = '0;
   logic [N-1:0] m_dg = '0;
   logic [N-1:0] s_gnt, s_dg;
   logic [31:0]  s_rd;

   typedef struct {
      logic [1:0]  r;
      logic [31:0] a0, a1;
      logic [3:0]  s0, s1;
      logic [31:0] d0, d1;
      logic [1:0]  eg;
      logic [1:0]  edg;
      logic [31:0] erd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] m_gnt(input logic [N-1:0] r);
      logic [N-1:0] g = '0;
      for (int i = 0; i < N; i++) if (r[i] && g == '0) g[i] = 1'b1;
      return g;
   endfunction

   // One bus cycle, started just after a falling edge.
   task automatic cyc(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [3:0] s0, input logic [3:0] s1,
                      input logic [31:0] d0, input logic [31:0] d1);
      logic [N-1:0] g;
      int i, w;
      logic [31:0] a;
      logic [3:0] s;
      logic [31:0] d;
      req = r; addr[0] = a0; addr[1] = a1; wstrb[0] = s0; wstrb[1] = s1;
      wdata[0] = d0; wdata[1] = d1;
      #1;
      s_gnt = gnt;
      g = m_gnt(r);
      chk("gnt", {30'd0, gnt}, {30'd0, g});
      @(posedge clk);
      m_dg = '0;
      if (g != '0) begin
         i = g[1] ? 1 : 0;
         a = i ? a1 : a0; s = i ? s1 : s0; d = i ? d1 : d0;
         w = int'(a / 4) % 8;
         if (s != 4'd0) begin
            for (int k = 0; k < 4; k++) if (s[k]) m_mem[w][8*k +: 8] = d[8*k +: 8];
         end else begin
            m_rdata = m_mem[w];
            m_dg = g;
         end
      end
      #1;
      s_dg = data_gnt;
      s_rd = rdata;
      chk("data_gnt", {30'd0, data_gnt}, {30'd0, m_dg});
      if (m_dg != '0) chk("rdata", rdata, m_rdata);
      @(negedge clk);
   endtask

   vec_t tbl [14];

   initial begin
      tbl[0]  = '{2'b11, 32'h0,  32'h4,  4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h00000001};
      tbl[1]  = '{2'b01, 32'h8,  32'h0,  4'hF, 4'h0, 32'hAABBCCDD, 32'h0, 2'b01, 2'b00, 32'h0};
      tbl[2]  = '{2'b01, 32'h8,  32'h0,  4'h1, 4'h0, 32'h00000011, 32'h0, 2'b01, 2'b00, 32'h0};
      tbl[3]  = '{2'b10, 32'h0,  32'h8,  4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 32'hAABBCC11};
      tbl[4]  = '{2'b01, 32'h20, 32'h0,  4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01, 2'b00, 32'h0};
      tbl[5]  = '{2'b01, 32'h0,  32'h0,  4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'hDEADBEEF};
      tbl[6]  = '{2'b10, 32'h0,  32'h3,  4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 32'hDEADBEEF};
      tbl[7]  = '{2'b10, 32'h0,  32'h0,  4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 32'hDEADBEEF};
      tbl[8]  = '{2'b01, 32'h4,  32'h0,  4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h11111111};
      tbl[9]  = '{2'b00, 32'h0,  32'h0,  4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};
      tbl[10] = '{2'b10, 32'h0,  32'h10, 4'h0, 4'hF, 32'h0, 32'h12345678, 2'b10, 2'b00, 32'h0};
      tbl[11] = '{2'b01, 32'h10, 32'h0,  4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h12345678};
      tbl[12] = '{2'b01, 32'h10, 32'h0,  4'h6, 4'h0, 32'hAABBCCDD, 32'h0, 2'b01, 2'b00, 32'h0};
      tbl[13] = '{2'b01, 32'h10, 32'h0,  4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h12BBCC78};

      // Reset state: outputs cleared, gnt still follows req.
      req = 2'b11;
      @(negedge clk);
      #1;
      chk("rst_gnt", {30'd0, gnt}, 32'd1);
      chk("rst_data_gnt", {30'd0, data_gnt}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      req = 2'b00;
      @(negedge clk);
      anrst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 8; k++)
         cyc(2'b01, 32'(k * 4), 32'h0, 4'hF, 4'h0, (k == 0) ? 32'h1 : 32'(k) * 32'h11111111, 32'h0);
      for (int k = 0; k < 8; k++) begin
         cyc(2'b01, 32'(k * 4), 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
         chk("load_dg", {30'd0, s_dg}, 32'd1);
         chk("load_rd", s_rd, (k == 0) ? 32'h1 : 32'(k) * 32'h11111111);
      end

      for (int v = 0; v < 14; v++) begin
         cyc(tbl[v].r, tbl[v].a0, tbl[v].a1, tbl[v].s0, tbl[v].s1, tbl[v].d0, tbl[v].d1);
         chk($sformatf("tbl%0d_gnt", v), {30'd0, s_gnt}, {30'd0, tbl[v].eg});
         chk($sformatf("tbl%0d_dg", v), {30'd0, s_dg}, {30'd0, tbl[v].edg});
         if (tbl[v].edg != 2'b00) chk($sformatf("tbl%0d_rd", v), s_rd, tbl[v].erd);
      end

      // Reset one cycle after a read accept; contents must survive.
      cyc(2'b01, 32'h4, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
      anrst = 1'b0;
      #1;
      chk("midrst_dg", {30'd0, data_gnt}, 32'd0);
      chk("midrst_rd", rdata, 32'd0);
      m_dg = '0;
      m_rdata = '0;
      @(negedge clk);
      anrst = 1'b1;
      @(negedge clk);
      cyc(2'b10, 32'h0, 32'h4, 4'h0, 4'h0, 32'h0, 32'h0);
      chk("postrst_rd", s_rd, 32'h11111111);

      for (int n = 0; n < 400; n++) begin
         logic [3:0] s0, s1;
         s0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         s1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         cyc(2'($urandom), $urandom, $urandom, s0, s1, $urandom, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
